rv32i_run_ctrl: RTL and testbench

RV32I_RUN_CTRL -- requirements
Module: rv32i_run_ctrl

---
 rtl/rv32i_run_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_rv32i_run_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_run_ctrl.sv
// ============================================================================
// rv32i_run_ctrl
// ----------------------------------------------------------------------------
// Wishbone-controlled run/step/halt sequencer for an RV32I core. It holds the
// core in reset, releases it, gates its clock enable for free-running,
// bounded-length or single-step execution, counts executed cycles, captures
// the core's write-back bus while it runs and raises an interrupt when a
// bounded run (or a breakpoint) completes.
//
// Register map (byte address, bits [3:2] select):
//   0x0 CTRL   W : b0 START, b1 HALT, b2 STEP, b3 HOLD (self-clearing),
//                  b4 OE (stored). Reads return {27'b0, OE, 4'b0}.
//   0x4 RUNCNT RW: run length in core cycles, 0 = free-run.
//   0x8 STATUS R : [31:16] CAP, [15:4] ELAPSED[11:0], [3] DONE, [2] 0,
//                  [1:0] state. Reading it clears DONE.
//   0xC BKPT   RW: {en[16], value[15:0]} when breakpoints are built in,
//                  otherwise reads 0 and ignores writes.
//
// Build option:
//   RV32I_RUN_CTRL_BKPT_EN - when defined, adds the BKPT register and the
//                            write-back breakpoint comparator.
//
// Ports:
//   clk          system clock (wb_clk_i)
//   RN           asynchronous active-low reset
//   wbs_cyc_i    bus cycle
//   wbs_stb_i    strobe
//   wbs_we_i     write enable
//   wbs_adr_i    byte address, [3:2] selects the register
//   wbs_dat_i    write data
//   wbs_dat_o    read data, valid while wbs_ack_o is high, 0 otherwise
//   wbs_ack_o    single-cycle acknowledge
//   core_wb_out  core write-back bus (captured into CAP)
//   core_rn_o    core reset, active-low
//   core_ce_o    core clock enable
//   io_oeb_o     pad output enables, active-low
//   irq_o        run-complete interrupt (mirrors DONE)
// ============================================================================
module rv32i_run_ctrl #(
    parameter int OUT_W = 16,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             RN,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_ack_o,
    input  logic [OUT_W-1:0] core_wb_out,
    output logic             core_rn_o,
    output logic             core_ce_o,
    output logic [OUT_W-1:0] io_oeb_o,
    output logic             irq_o
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_HALT = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_RUNCNT = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BKPT   = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               ce_q;
    logic               rn_q;
    logic               oe_q;
    logic               done_q;
    logic [CNT_W-1:0]   runcnt_q;
    logic [CNT_W-1:0]   elapsed_q;
    logic [OUT_W-1:0]   cap_q;
    logic               ack_q;
    logic [31:0]        dat_q;

    // ------------------------------------------------------------------
    // Bus decode. An access is taken only while ack is low, so back-to-back
    // requests are accepted at most every second cycle; every register write
    // and command lands on the same edge that raises ack.
    // ------------------------------------------------------------------
    logic       bus_access;
    logic       bus_wr;
    logic       bus_rd;
    logic [1:0] reg_sel;
    logic       ctrl_wr;
    logic       cmd_start;
    logic       cmd_halt;
    logic       cmd_step;
    logic       cmd_hold;
    logic       status_rd;

    assign bus_access = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign bus_wr     = bus_access &  wbs_we_i;
    assign bus_rd     = bus_access & ~wbs_we_i;
    assign reg_sel    = wbs_adr_i[3:2];
    assign ctrl_wr    = bus_wr && (reg_sel == REG_CTRL);
    assign cmd_start  = ctrl_wr & wbs_dat_i[0];
    assign cmd_halt   = ctrl_wr & wbs_dat_i[1];
    assign cmd_step   = ctrl_wr & wbs_dat_i[2];
    assign cmd_hold   = ctrl_wr & wbs_dat_i[3];
    assign status_rd  = bus_rd && (reg_sel == REG_STATUS);

    // Byte-address bits [1:0] and upper data bits are don't-care for this
    // register file; folding them here keeps the intent explicit.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{wbs_dat_i, wbs_adr_i[1:0]};

    // ------------------------------------------------------------------
    // Optional write-back breakpoint
    // ------------------------------------------------------------------
    logic bkpt_hit;

`ifdef RV32I_RUN_CTRL_BKPT_EN
    logic        bkpt_en_q;
    logic [15:0] bkpt_val_q;

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            bkpt_en_q  <= 1'b0;
            bkpt_val_q <= '0;
        end else if (bus_wr && (reg_sel == REG_BKPT)) begin
            bkpt_en_q  <= wbs_dat_i[16];
            bkpt_val_q <= wbs_dat_i[15:0];
        end
    end

    assign bkpt_hit = bkpt_en_q && (16'(core_wb_out) == bkpt_val_q);
`else
    assign bkpt_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Run termination: the cycle now executing is the last one when
    // ELAPSED+1 reaches a non-zero RUNCNT, or when the breakpoint matches.
    // ce_q is always high in RUN, so qualifying on the state suffices.
    // ------------------------------------------------------------------
    logic tc_hit;
    logic stop_hit;

    assign tc_hit   = (runcnt_q != '0) && ((elapsed_q + CNT_W'(1)) == runcnt_q);
    assign stop_hit = (state_q == ST_RUN) && ce_q && (tc_hit || bkpt_hit);

    // ------------------------------------------------------------------
    // Next-state logic. HOLD beats everything; within the remaining
    // commands HALT > START > STEP. START is only honoured from HOLD/HALT,
    // STEP only from HALT.
    // ------------------------------------------------------------------
    logic start_go;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so
        // that no path leaves it unassigned and infers a latch.
        state_d  = state_q;
        start_go = 1'b0;
        if (cmd_hold) begin
            state_d = ST_HOLD;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (!cmd_halt && cmd_start) begin
                        state_d  = ST_RUN;
                        start_go = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (cmd_halt) begin
                        state_d = ST_HALT;
                    end else if (cmd_start) begin
                        state_d  = ST_RUN;
                        start_go = 1'b1;
                    end else if (cmd_step) begin
                        state_d = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (cmd_halt || stop_hit) begin
                        state_d = ST_HALT;
                    end
                end
                ST_STEP: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    // Core controls are decoded from the next state and registered, so the
    // enable and reset release line up with the cycle the state is entered.
    logic ce_d;
    logic rn_d;

    assign ce_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    assign rn_d = (state_d != ST_HOLD);

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_CTRL:   rdata = {27'b0, oe_q, 4'b0};
            REG_RUNCNT: rdata = 32'(runcnt_q);
            REG_STATUS: rdata = {16'(cap_q), elapsed_q[11:0], done_q, 1'b0, state_q};
`ifdef RV32I_RUN_CTRL_BKPT_EN
            REG_BKPT:   rdata = {15'b0, bkpt_en_q, bkpt_val_q};
`else
            REG_BKPT:   rdata = '0;
`endif
            default:    rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // NOTE: all state here is a handful of control flops, so every one gets
    // an asynchronous reset; a mid-run reset therefore aborts cleanly
    // without DONE ever being set.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q <= ST_HOLD;
            ce_q    <= 1'b0;
            rn_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            ce_q    <= ce_d;
            rn_q    <= rn_d;
        end
    end

    // Cycle counter: restarts on START, otherwise advances on every enabled
    // core cycle and wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            elapsed_q <= '0;
        end else if (start_go) begin
            elapsed_q <= '0;
        end else if (ce_q) begin
            elapsed_q <= elapsed_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            cap_q <= '0;
        end else if (ce_q) begin
            cap_q <= core_wb_out;
        end
    end

    // DONE: a completion in the same cycle as a clear (STATUS read or START)
    // must not be lost, so set has priority.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            done_q <= 1'b0;
        end else if (stop_hit) begin
            done_q <= 1'b1;
        end else if (status_rd || start_go) begin
            done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            oe_q     <= 1'b0;
            runcnt_q <= '0;
        end else begin
            if (ctrl_wr) begin
                oe_q <= wbs_dat_i[4];
            end
            if (bus_wr && (reg_sel == REG_RUNCNT)) begin
                runcnt_q <= wbs_dat_i[CNT_W-1:0];
            end
        end
    end

    // Bus response: ack is a one-cycle pulse, read data is only driven
    // while ack is high.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= bus_access;
            dat_q <= bus_rd ? rdata : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign core_rn_o = rn_q;
    assign core_ce_o = ce_q;
    assign io_oeb_o  = {OUT_W{~oe_q}};
    assign irq_o     = done_q;

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// ============================================================================
// tb_rv32i_run_ctrl
// ----------------------------------------------------------------------------
// Directed bench for rv32i_run_ctrl. Bus reads push their hand-computed
// expected data into a scoreboard queue; an independent monitor pops and
// compares whenever the DUT raises wbs_ack_o. Core-side outputs are checked
// directly at points away from the rising edge.
// ============================================================================
`timescale 1ns/1ps

module tb_rv32i_run_ctrl;

    localparam int OUT_W = 16;
    localparam int CNT_W = 24;

    logic             clk;
    logic             RN;
    logic             wbs_cyc_i;
    logic             wbs_stb_i;
    logic             wbs_we_i;
    logic [3:0]       wbs_adr_i;
    logic [31:0]      wbs_dat_i;
    logic [31:0]      wbs_dat_o;
    logic             wbs_ack_o;
    logic [OUT_W-1:0] core_wb_out;
    logic             core_rn_o;
    logic             core_ce_o;
    logic [OUT_W-1:0] io_oeb_o;
    logic             irq_o;

    rv32i_run_ctrl #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .RN          (RN),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_ack_o   (wbs_ack_o),
        .core_wb_out (core_wb_out),
        .core_rn_o   (core_rn_o),
        .core_ce_o   (core_ce_o),
        .io_oeb_o    (io_oeb_o),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry; reads are compared.
    always @(negedge clk) begin
        if (RN && wbs_ack_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with data 0x%08h, expected no ack", wbs_dat_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk) check(e.name, wbs_dat_o, e.exp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus driver
    // ------------------------------------------------------------------
    task automatic bus(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                       input logic chk, input logic [31:0] exp, input string name);
        exp_t e;
        logic got;
        e.chk  = chk;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk);
            #1;
            got = wbs_ack_o;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack in 8 cycles, expected ack", name);
            if (sb.size() > 0) e = sb.pop_back();
        end
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input string name);
        bus(1'b1, adr, dat, 1'b0, 32'd0, name);
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'd0, 1'b1, exp, name);
    endtask

    task automatic count_ce(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (core_ce_o) cnt++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_rn"}, 32'(core_rn_o), 32'd0);
        check({tag, "_core_ce"}, 32'(core_ce_o), 32'd0);
        check({tag, "_io_oeb"},  32'(io_oeb_o),  32'h0000_FFFF);
        check({tag, "_irq"},     32'(irq_o),     32'd0);
        check({tag, "_ack"},     32'(wbs_ack_o), 32'd0);
        check({tag, "_dat"},     wbs_dat_o,      32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int cnt;
        RN          = 1'b0;
        wbs_cyc_i   = 1'b0;
        wbs_stb_i   = 1'b0;
        wbs_we_i    = 1'b0;
        wbs_adr_i   = 4'h0;
        wbs_dat_i   = 32'd0;
        core_wb_out = 16'h1234;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        RN = 1'b1;
        rd(4'h8, 32'h0000_0000, "status_after_reset");
        rd(4'h0, 32'h0000_0000, "ctrl_after_reset");
        rd(4'h4, 32'h0000_0000, "runcnt_after_reset");
        rd(4'hC, 32'h0000_0000, "bkpt_after_reset");

        // START from HOLD: RUN with core released and enabled
        wr(4'h0, 32'h01, "start_free");
        check("start_core_rn", 32'(core_rn_o), 32'd1);
        check("start_core_ce", 32'(core_ce_o), 32'd1);
        // CAP=0x1234, ELAPSED=1, DONE=0, state RUN
        rd(4'h8, 32'h1234_0012, "status_running");

        // All commands at once: HOLD wins
        wr(4'h0, 32'h0F, "all_cmds");
        check("hold_core_rn", 32'(core_rn_o), 32'd0);
        check("hold_core_ce", 32'(core_ce_o), 32'd0);
        rd(4'h8, 32'h1234_0040, "status_held");

        // Pad output enables
        wr(4'h0, 32'h10, "oe_on");
        check("oe_on_io_oeb", 32'(io_oeb_o), 32'h0000_0000);
        rd(4'h0, 32'h0000_0010, "ctrl_oe_readback");
        wr(4'h0, 32'h00, "oe_off");
        check("oe_off_io_oeb", 32'(io_oeb_o), 32'h0000_FFFF);

        // Bounded run of 5 cycles
        wr(4'h4, 32'd5, "runcnt5");
        rd(4'h4, 32'd5, "runcnt5_readback");
        core_wb_out = 16'hBEEF;
        wr(4'h0, 32'h01, "start_bounded");
        count_ce(20, cnt);
        check("bounded_ce_cycles", 32'(cnt), 32'd5);
        check("bounded_irq_set", 32'(irq_o), 32'd1);
        // CAP=BEEF, ELAPSED=5, DONE=1, state HALT
        rd(4'h8, 32'hBEEF_0059, "status_done");
        check("irq_cleared_by_read", 32'(irq_o), 32'd0);
        rd(4'h8, 32'hBEEF_0051, "status_after_clear");

        // Three single steps from HALT; ELAPSED 5 -> 8, CAP from last pulse
        core_wb_out = 16'h1111;
        wr(4'h0, 32'h04, "step1");
        count_ce(4, cnt);
        check("step1_ce_cycles", 32'(cnt), 32'd1);
        core_wb_out = 16'h2222;
        wr(4'h0, 32'h04, "step2");
        count_ce(4, cnt);
        check("step2_ce_cycles", 32'(cnt), 32'd1);
        core_wb_out = 16'h3333;
        wr(4'h0, 32'h04, "step3");
        count_ce(4, cnt);
        check("step3_ce_cycles", 32'(cnt), 32'd1);
        rd(4'h8, 32'h3333_0081, "status_after_steps");

        // Asynchronous reset in the middle of a long run
        wr(4'h4, 32'd100, "runcnt100");
        wr(4'h0, 32'h01, "start_long");
        repeat (3) @(negedge clk);
        #2 RN = 1'b0;
        #1 check_reset_outputs("midrun");
        repeat (4) @(negedge clk);
        check("midrun_irq_held", 32'(irq_o), 32'd0);
        RN = 1'b1;
        rd(4'h8, 32'h0000_0000, "status_after_midrun_reset");
        rd(4'h4, 32'h0000_0000, "runcnt_after_midrun_reset");

`ifdef RV32I_RUN_CTRL_BKPT_EN
        // Breakpoint on write-back value 0x00AA during a free run
        wr(4'hC, 32'h0001_00AA, "bkpt_set");
        rd(4'hC, 32'h0001_00AA, "bkpt_readback");
        core_wb_out = 16'h0000;
        wr(4'h0, 32'h01, "start_bkpt");
        @(negedge clk);
        core_wb_out = 16'h00AA;
        @(negedge clk);
        check("bkpt_core_ce", 32'(core_ce_o), 32'd0);
        check("bkpt_irq", 32'(irq_o), 32'd1);
        rd(4'h8, 32'h00AA_0019, "status_bkpt");
`else
        // Without breakpoints 0xC is inert and a free run never stops
        wr(4'hC, 32'h0001_00AA, "bkpt_set");
        rd(4'hC, 32'h0000_0000, "bkpt_absent");
        core_wb_out = 16'h00AA;
        wr(4'h0, 32'h01, "start_free2");
        count_ce(10, cnt);
        check("free_run_ce_cycles", 32'(cnt), 32'd10);
        check("free_run_irq", 32'(irq_o), 32'd0);
        wr(4'h0, 32'h08, "hold_end");
`endif

        // Drain the scoreboard
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
